// File: rtl/pixel_serializer_if.sv
// Pixel-in / beat-out handshake bundle for pixel_serializer.
// slave is the serializer's view; master is the source/sink side.
interface pixel_serializer_if #(
  parameter int PIXEL_W = 8,
  parameter int OUT_W   = 2,
  parameter int ADDR_W  = 24
);
  logic [PIXEL_W-1:0] pixel;
  logic               pixel_valid;
  logic               pixel_ready;
  logic               stall;
  logic               axiov;
  logic [OUT_W-1:0]   axiod;
  logic [ADDR_W-1:0]  pixel_addr;
  logic               frame_done;

  modport slave (
    input  pixel, pixel_valid, stall,
    output pixel_ready, axiov, axiod, pixel_addr, frame_done
  );

  modport master (
    output pixel, pixel_valid, stall,
    input  pixel_ready, axiov, axiod, pixel_addr, frame_done
  );
endinterface

// File: rtl/pixel_serializer.sv
// Double-buffered pixel-to-beat serializer with frame address tracking.
// Active shift register feeds the beat stream; a hold register absorbs one pixel of lookahead.
module pixel_serializer #(
  parameter int PIXEL_W      = 8,
  parameter int OUT_W        = 2,
  parameter int ADDR_W       = 24,
  parameter int FRAME_PIXELS = 76800,
  parameter int LSB_FIRST    = 1
) (
  input  logic               clk,
  input  logic               rst,
  pixel_serializer_if.slave  s
);
  localparam int N      = PIXEL_W / OUT_W;
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  logic [PIXEL_W-1:0] r_act;
  logic [PIXEL_W-1:0] r_hold;
  logic               r_act_valid;
  logic               r_hold_valid;
  logic [BEAT_W-1:0]  r_beat;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_axiov;
  logic [OUT_W-1:0]   r_axiod;
  logic               r_frame_done;

  logic               w_fire;
  logic               w_last;
  logic               w_accept;
  logic               w_wrap;
  logic [OUT_W-1:0]   w_emit;
  logic [PIXEL_W-1:0] w_shifted;

  assign w_fire   = r_act_valid && !s.stall;
  assign w_last   = w_fire && (r_beat == LAST_BEAT);
  assign w_accept = s.pixel_valid && !r_hold_valid;
  assign w_wrap   = (r_addr == LAST_ADDR);

  // The emit end of the shift register depends on bit order.
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign w_emit    = r_act[OUT_W-1:0];
      assign w_shifted = r_act >> OUT_W;
    end else begin : g_msb
      assign w_emit    = r_act[PIXEL_W-1 -: OUT_W];
      assign w_shifted = r_act << OUT_W;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act        <= '0;
      r_hold       <= '0;
      r_act_valid  <= 1'b0;
      r_hold_valid <= 1'b0;
      r_beat       <= '0;
      r_addr       <= '0;
      r_axiov      <= 1'b0;
      r_axiod      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_axiov      <= w_fire;
      r_axiod      <= w_fire ? w_emit : '0;
      r_frame_done <= w_last && w_wrap;

      if (w_fire) begin
        r_beat <= w_last ? '0 : r_beat + 1'b1;
        r_act  <= w_shifted;
      end

      if (w_last) begin
        r_addr <= w_wrap ? '0 : r_addr + 1'b1;
        if (r_hold_valid) begin
          r_act        <= r_hold;
          r_hold_valid <= 1'b0;
        end else if (!w_accept) begin
          r_act_valid <= 1'b0;
        end
      end

      // Accept never coincides with a hold move: it needs the hold slot empty.
      if (w_accept) begin
        if (!r_act_valid || w_last) begin
          r_act       <= s.pixel;
          r_act_valid <= 1'b1;
        end else begin
          r_hold       <= s.pixel;
          r_hold_valid <= 1'b1;
        end
      end
    end
  end

  assign s.pixel_ready = !r_hold_valid;
  assign s.axiov       = r_axiov;
  assign s.axiod       = r_axiod;
  assign s.pixel_addr  = r_addr;
  assign s.frame_done  = r_frame_done;
endmodule
